// File: rtl/playback_timer_pkg.sv
// Shared constants for the playback timer: FSM state encodings and the
// seconds-per-minute divisor used by the seek conversion.
package playback_timer_pkg;

  localparam logic [1:0] ST_COUNT = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/playback_timer_if.sv
// Control/status bundle between the player controller (master) and the
// playback timer (slave).
interface playback_timer_if #(
  parameter int SEC_W = 16,
  parameter int MIN_W = 10
);
  logic             run;
  logic             clr;
  logic             load;
  logic [SEC_W-1:0] load_sec;
  logic [SEC_W-1:0] track_len;
  logic [SEC_W-1:0] time_sec;
  logic [MIN_W-1:0] min;
  logic [5:0]       sec;
  logic [SEC_W-1:0] remain_sec;
  logic             sec_tick;
  logic             busy;
  logic             end_pulse;
  logic             done;

  modport master (
    output run, clr, load, load_sec, track_len,
    input  time_sec, min, sec, remain_sec, sec_tick, busy, end_pulse, done
  );

  modport slave (
    input  run, clr, load, load_sec, track_len,
    output time_sec, min, sec, remain_sec, sec_tick, busy, end_pulse, done
  );
endinterface

// File: rtl/playback_timer_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICKS_PER_SEC
// enabled cycles; the phase is frozen while disabled.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            CW   = $clog2(TICKS_PER_SEC);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // A clear on the wrap edge wins, so that second is never counted.
  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/playback_timer.sv
// Playback-time counter: elapsed seconds with pause, clear and seek, a
// serial seconds-to-min/sec conversion after seek, and end-of-track flagging.
module playback_timer
  import playback_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000000,
  parameter int SEC_W         = 16,
  parameter int MIN_W         = 10,
  parameter bit WRAP          = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  playback_timer_if.slave  bus
);
  // Conversion remainder must hold 0..59 even when SEC_W is narrow.
  localparam int RW = (SEC_W > 7) ? SEC_W : 7;

  logic [1:0]       state;
  logic [SEC_W-1:0] time_sec;
  logic [SEC_W-1:0] time_inc;
  logic [SEC_W-1:0] target;
  logic [MIN_W-1:0] min_q;
  logic [5:0]       sec_q;
  logic [RW-1:0]    conv_rem;
  logic             end_pulse_q;
  logic             tick;
  logic             presc_en;
  logic             presc_clr;
  logic             track_bounded;

  assign track_bounded = (bus.track_len != '0);
  assign time_inc      = time_sec + SEC_W'(1);
  assign presc_en      = (state == ST_COUNT) && bus.run;
  assign presc_clr     = bus.clr || bus.load || (state != ST_COUNT);

  tick_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    target = bus.load_sec;
    if (track_bounded && (bus.load_sec > bus.track_len))
      target = bus.track_len;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_COUNT;
      time_sec    <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      conv_rem    <= '0;
      end_pulse_q <= 1'b0;
    end else begin
      end_pulse_q <= 1'b0;
      if (bus.clr) begin
        state    <= ST_COUNT;
        time_sec <= '0;
        min_q    <= '0;
        sec_q    <= '0;
        conv_rem <= '0;
      end else if (bus.load) begin
        state    <= ST_CONV;
        time_sec <= target;
        conv_rem <= RW'(target);
        min_q    <= '0;
      end else begin
        case (state)
          ST_COUNT: begin
            if (tick) begin
              if (time_sec == '1) begin
                if (WRAP) begin
                  time_sec <= '0;
                  min_q    <= '0;
                  sec_q    <= '0;
                end
              end else begin
                time_sec <= time_inc;
                if (sec_q == 6'(SEC_PER_MIN - 1)) begin
                  sec_q <= '0;
                  if (min_q != '1) min_q <= min_q + MIN_W'(1);
                end else begin
                  sec_q <= sec_q + 6'd1;
                end
                if (track_bounded && (time_inc == bus.track_len)) begin
                  state       <= ST_DONE;
                  end_pulse_q <= 1'b1;
                end
              end
            end
          end
          ST_CONV: begin
            if (conv_rem >= RW'(SEC_PER_MIN)) begin
              conv_rem <= conv_rem - RW'(SEC_PER_MIN);
              if (min_q != '1) min_q <= min_q + MIN_W'(1);
            end else begin
              sec_q <= conv_rem[5:0];
              // TIME_SEC still holds the seek target while converting.
              if (track_bounded && (time_sec == bus.track_len)) begin
                state       <= ST_DONE;
                end_pulse_q <= 1'b1;
              end else begin
                state <= ST_COUNT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.remain_sec = '0;
    if (track_bounded && (bus.track_len > time_sec))
      bus.remain_sec = bus.track_len - time_sec;
  end

  assign bus.time_sec  = time_sec;
  assign bus.min       = min_q;
  assign bus.sec       = sec_q;
  assign bus.sec_tick  = tick;
  assign bus.busy      = (state == ST_CONV);
  assign bus.done      = (state == ST_DONE);
  assign bus.end_pulse = end_pulse_q;

endmodule

// File: tb/tb_playback_timer.sv
// Directed bench for playback_timer: a 16-bit instance for the main flows and
// two 4-bit instances contrasting wrap and saturate overflow.
module tb_playback_timer;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  playback_timer_if #(.SEC_W(16), .MIN_W(10)) bus_a ();
  playback_timer_if #(.SEC_W(4),  .MIN_W(10)) bus_b ();
  playback_timer_if #(.SEC_W(4),  .MIN_W(10)) bus_c ();

  playback_timer #(.TICKS_PER_SEC(4), .SEC_W(16), .MIN_W(10), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  playback_timer #(.TICKS_PER_SEC(4), .SEC_W(4), .MIN_W(10), .WRAP(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));
  playback_timer #(.TICKS_PER_SEC(4), .SEC_W(4), .MIN_W(10), .WRAP(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int ep;
    int n;

    rst_n = 1'b0;
    bus_a.run = 0; bus_a.clr = 0; bus_a.load = 0; bus_a.load_sec = '0; bus_a.track_len = '0;
    bus_b.run = 0; bus_b.clr = 0; bus_b.load = 0; bus_b.load_sec = '0; bus_b.track_len = '0;
    bus_c.run = 0; bus_c.clr = 0; bus_c.load = 0; bus_c.load_sec = '0; bus_c.track_len = '0;
    step(1);
    check("rst_time", 32'(bus_a.time_sec), 0);
    check("rst_min", 32'(bus_a.min), 0);
    check("rst_sec", 32'(bus_a.sec), 0);
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_done", 32'(bus_a.done), 0);
    check("rst_tick", 32'(bus_a.sec_tick), 0);

    // Free run: 40 cycles at 4 cycles/s gives 10 s
    rst_n = 1'b1;
    bus_a.run = 1'b1;
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (bus_a.sec_tick) ticks++;
    end
    check("run_ticks", 32'(ticks), 10);
    check("run_time", 32'(bus_a.time_sec), 10);
    check("run_min", 32'(bus_a.min), 0);
    check("run_sec", 32'(bus_a.sec), 10);

    // Pause keeps the sub-second phase: 2 run cycles, pause, 2 more to tick
    step(2);
    bus_a.run = 1'b0;
    step(10);
    check("pause_time", 32'(bus_a.time_sec), 10);
    check("pause_tick", 32'(bus_a.sec_tick), 0);
    bus_a.run = 1'b1;
    step(1);
    check("resume_tick", 32'(bus_a.sec_tick), 1);
    check("resume_time_hold", 32'(bus_a.time_sec), 10);
    step(1);
    check("resume_time", 32'(bus_a.time_sec), 11);

    // Seek to 125 s: three conversion cycles, then 2:05
    bus_a.load_sec = 16'd125;
    bus_a.load = 1'b1;
    step(1);
    bus_a.load = 1'b0;
    check("seek_time", 32'(bus_a.time_sec), 125);
    n = 0;
    while (bus_a.busy && n < 20) begin
      n++;
      step(1);
    end
    check("seek_busy_cycles", 32'(n), 3);
    check("seek_min", 32'(bus_a.min), 2);
    check("seek_sec", 32'(bus_a.sec), 5);
    step(4);
    check("seek_next_time", 32'(bus_a.time_sec), 126);
    check("seek_next_min", 32'(bus_a.min), 2);
    check("seek_next_sec", 32'(bus_a.sec), 6);

    // Bounded track of 3 s
    bus_a.clr = 1'b1;
    bus_a.track_len = 16'd3;
    step(1);
    bus_a.clr = 1'b0;
    check("clr_time", 32'(bus_a.time_sec), 0);
    ep = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (bus_a.end_pulse) begin
        ep++;
        check("end_at_len", 32'(bus_a.time_sec), 3);
      end
      if (i == 4) check("remain_mid", 32'(bus_a.remain_sec), 2);
    end
    check("end_pulse_cnt", 32'(ep), 1);
    check("end_done", 32'(bus_a.done), 1);
    check("end_remain", 32'(bus_a.remain_sec), 0);
    ticks = 0;
    for (int i = 0; i < 80; i++) begin
      step(1);
      if (bus_a.end_pulse) ep++;
      if (bus_a.sec_tick) ticks++;
    end
    check("done_pulse_cnt", 32'(ep), 1);
    check("done_no_ticks", 32'(ticks), 0);
    check("done_time_hold", 32'(bus_a.time_sec), 3);
    check("done_hold", 32'(bus_a.done), 1);
    bus_a.clr = 1'b1;
    step(1);
    bus_a.clr = 1'b0;
    bus_a.run = 1'b0;
    check("done_clr_done", 32'(bus_a.done), 0);
    check("done_clr_time", 32'(bus_a.time_sec), 0);
    check("done_clr_remain", 32'(bus_a.remain_sec), 3);

    // 4-bit overflow: 16 ticks wraps to 0 vs saturates at 15
    bus_b.run = 1'b1;
    bus_c.run = 1'b1;
    ticks = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (bus_c.sec_tick) ticks++;
    end
    check("wrap_time", 32'(bus_b.time_sec), 0);
    check("wrap_sec", 32'(bus_b.sec), 0);
    check("sat_time", 32'(bus_c.time_sec), 15);
    check("sat_sec", 32'(bus_c.sec), 15);
    check("sat_ticks", 32'(ticks), 16);

    // Seek past the end of a 10 s track clamps and finishes
    bus_a.load_sec = 16'd20;
    bus_a.track_len = 16'd10;
    bus_a.load = 1'b1;
    step(1);
    bus_a.load = 1'b0;
    check("clamp_busy", 32'(bus_a.busy), 1);
    check("clamp_time", 32'(bus_a.time_sec), 10);
    step(1);
    check("clamp_busy_end", 32'(bus_a.busy), 0);
    check("clamp_done", 32'(bus_a.done), 1);
    check("clamp_end_pulse", 32'(bus_a.end_pulse), 1);
    check("clamp_sec", 32'(bus_a.sec), 10);
    check("clamp_min", 32'(bus_a.min), 0);
    step(1);
    check("clamp_pulse_once", 32'(bus_a.end_pulse), 0);

    // Reset beats CLR and LOAD mid-conversion; then CLR beats LOAD
    bus_a.track_len = '0;
    bus_a.load_sec = 16'd125;
    bus_a.load = 1'b1;
    step(1);
    bus_a.load = 1'b0;
    step(1);
    check("mid_conv_busy", 32'(bus_a.busy), 1);
    bus_a.load = 1'b1;
    bus_a.clr = 1'b1;
    rst_n = 1'b0;
    step(1);
    check("prio_rst_time", 32'(bus_a.time_sec), 0);
    check("prio_rst_min", 32'(bus_a.min), 0);
    check("prio_rst_sec", 32'(bus_a.sec), 0);
    check("prio_rst_busy", 32'(bus_a.busy), 0);
    check("prio_rst_done", 32'(bus_a.done), 0);
    check("prio_rst_remain", 32'(bus_a.remain_sec), 0);
    rst_n = 1'b1;
    bus_a.load_sec = 16'd50;
    step(1);
    check("prio_clr_busy", 32'(bus_a.busy), 0);
    check("prio_clr_time", 32'(bus_a.time_sec), 0);
    bus_a.load = 1'b0;
    bus_a.clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
